clkdiv_prog: RTL
================

# clkdiv_prog

Runtime-programmable integer clock divider. It generalises the fixed divide-by-5 block to any divisor from 2 to 2^DIV_W−1, with a selectable exact-50% duty mode for odd divisors. Divisor changes are glitch-free and take effect at period boundaries, confirmed by an acknowledge pulse. It sits in the clock-generation path of the S/PDIF-to-I2S bridge and derives the bit/word clocks from the recovered master clock. It also provides a `tick` strobe that downstream logic uses as a clock enable.

## Interface
- `DIV_W`, 8: divisor width in bits.
- `DEFAULT_DIV`, 5: divisor loaded at reset; must be ≥2.
- `ACCURATE_NEG_EDGE`, 0: 1 = odd divisors give exact 50% duty using a clk_in negedge stage; 0 = posedge only.

Ports:
- `clk_in`  in  1  — the single clock. Both edges are used when ACCURATE_NEG_EDGE=1.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `en`  in  1  — run request.
- `div_in`  in  DIV_W  — new divisor N.
- `div_load`  in  1  — one-cycle request to latch `div_in`.
- `div_ack`  out  1  — one-cycle pulse in the cycle the new divisor becomes active.
- `clk_out`  out  1  — divided clock.
- `tick`  out  1  — one-cycle strobe, registered, high for the clk_in cycle in which clk_out rises.
- `busy`  out  1  — high while a loaded divisor is pending.

## Operation
- **State:**
  - `cnt[DIV_W-1:0]`, `div_cur`, `div_pend`, `pend`, `running`.
  - `q_pos` (posedge flop).
  - `q_neg` (negedge flop; holds q_pos sampled on negedge).
- **Clamp:** a `div_in` value of 0 or 1 is stored as 2.
- **IDLE (running=0):**
  - cnt=0; q_pos=0.
  - At a posedge with en=1: running←1, cnt←0, q_pos←1, tick←1.
  - At that same posedge, a pending divisor is applied (div_ack←1).
- **RUN, posedge:**
  - If cnt≠N−1: cnt←cnt+1.
  - If cnt=N−1 (wrap):
    - en=0: running←0, cnt←0, q_pos←0. No tick. The period always completes.
    - en=1: cnt←0, q_pos←1, tick←1. If pend: div_cur←div_pend, pend←0, div_ack←1.
  - q_pos holds the registered value of next_cnt < H, where H is the high-phase length in cycles:
    - N even: H = N/2.
    - N odd, ACCURATE_NEG_EDGE=1: H = (N−1)/2.
    - N odd, ACCURATE_NEG_EDGE=0: H = (N−1)/2.
  - H is computed from the divisor in force after the edge.
- **Output:**
  - ACCURATE_NEG_EDGE=1 and N odd: clk_out = q_pos | q_neg. This gives a high time of (N−1)/2 + ½ cycles, i.e. exactly N/2.
  - Otherwise: clk_out = q_pos.
  - The odd/even select is registered with div_cur so it never changes mid-period.
- **Divisor load:**
  - div_load at a posedge: div_pend←clamped div_in, pend←1.
  - A second div_load while pending overwrites div_pend; only one div_ack is issued.
  - If div_load arrives on the same posedge as a wrap, the new value is taken at the following wrap. The old pend value, if any, is applied now.
  - While IDLE with en=0: the divisor is applied on the next posedge (div_ack then).
- **busy** = pend.
- **Glitch-freedom:** clk_out changes only at defined edges. There are no runt pulses on divisor change or on en toggling.

## Timing
- **Reset (asynchronous, on reset_n low):**
  - cnt=0, running=0, q_pos=0, q_neg=0, pend=0, div_cur=DEFAULT_DIV.
  - Outputs: clk_out=0, tick=0, div_ack=0, busy=0.
  - Release is synchronous to the next clk_in posedge.
  - Reset mid-period drops clk_out to 0 immediately. The pending divisor is discarded.
- **Start latency:** clk_out rises after the first posedge that samples en=1 in IDLE. tick is high for that same cycle.
- **Period:** exactly N clk_in cycles between clk_out rising edges. The rising edge is always posedge-aligned.
- **tick:** exactly one per period, coincident with the rising cycle. Its duty is 1/N.
- **div_ack:** coincides with the first tick of the new period.
- **en deassert:** clk_out finishes its current period, falls at the normal point, and then stays low.
- **Throughput:** back-to-back periods with no gap while en=1, including across divisor changes.

## Test plan
- Reset: hold reset_n=0 with en=1 → clk_out=0, tick=0, busy=0, div_ack=0. Release → first rising edge one posedge after release, period 5.
- N=5, ACCURATE_NEG_EDGE=1 → period 5 cycles, high 2.5 cycles (falls on negedge), tick every 5th cycle.
- N=5, ACCURATE_NEG_EDGE=0 → period 5, high 2 cycles. N=4 → high 2, low 2.
- Running at N=4, div_load div_in=7 mid-period → busy=1. The current period completes as 4 cycles. div_ack and tick occur together at the boundary; subsequent periods are 7 cycles with high phase 3.5.
- div_in=0 and div_in=1 → both produce period 2, high 1.
- en dropped at cnt=1 of an N=6 period → 6-cycle period completes, clk_out stays low, no further ticks. en re-raised → rise on the next posedge.
- reset_n pulsed low mid-high-phase with a load pending → clk_out=0 asynchronously. After release: divisor is DEFAULT_DIV, busy=0, and no div_ack is issued.

Source files
------------

// File: rtl/clkdiv_prog.sv
// ---------------------------------------------------------------------------
// clkdiv_prog
// Runtime-programmable integer clock divider (N = 2 .. 2^DIV_W-1).
// Divisor changes are applied only at period boundaries and confirmed with a
// one-cycle div_ack. Odd divisors can optionally get an exact 50% duty cycle
// through an extra clk_in negedge stage.
//
// Parameters:
//   DIV_W             divisor width in bits
//   DEFAULT_DIV       divisor in force after reset (must be >= 2)
//   ACCURATE_NEG_EDGE 1: odd N gives exact 50% duty, 0: posedge-only output
//
// Ports:
//   clk_in    in   clock (both edges used when ACCURATE_NEG_EDGE = 1)
//   reset_n   in   asynchronous active-low reset
//   en        in   run request; the current period always completes
//   div_in    in   new divisor (0 and 1 are stored as 2)
//   div_load  in   one-cycle request to latch div_in
//   div_ack   out  pulse in the cycle the new divisor becomes active
//   clk_out   out  divided clock, rising edge posedge-aligned
//   tick      out  strobe for the clk_in cycle in which clk_out rises
//   busy      out  a loaded divisor is still pending
// ---------------------------------------------------------------------------
module clkdiv_prog #(
    parameter int DIV_W             = 8,
    parameter int DEFAULT_DIV       = 5,
    parameter int ACCURATE_NEG_EDGE = 0
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);
    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
    localparam logic [DIV_W-1:0] ZERO     = DIV_W'(0);
    localparam bit               NEG_MODE = (ACCURATE_NEG_EDGE != 0);

    // Divisors below 2 cannot produce a clock; store them as 2.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        logic [DIV_W-1:0] r;
        if (d < DIV_MIN) begin
            r = DIV_MIN;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // High-phase length on the posedge grid: N/2 for even N, (N-1)/2 for odd N.
    function automatic logic [DIV_W-1:0] high_len(input logic [DIV_W-1:0] d);
        return {1'b0, d[DIV_W-1:1]};
    endfunction

    logic [DIV_W-1:0] cnt_r, cnt_s;
    logic [DIV_W-1:0] div_cur_r, div_cur_s;
    logic [DIV_W-1:0] div_pend_r, div_pend_s;
    logic             pend_r, pend_s;
    logic             running_r, running_s;
    logic             q_pos_r, q_pos_s;
    logic             q_neg_r;
    logic             tick_r, tick_s;
    logic             ack_r, ack_s;
    logic             start_s;
    logic             apply_s;

    // State register: counter, divisor bookkeeping and posedge output stage.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r      <= ZERO;
            div_cur_r  <= DIV_RST;
            div_pend_r <= DIV_RST;
            pend_r     <= 1'b0;
            running_r  <= 1'b0;
            q_pos_r    <= 1'b0;
            tick_r     <= 1'b0;
            ack_r      <= 1'b0;
        end else begin
            cnt_r      <= cnt_s;
            div_cur_r  <= div_cur_s;
            div_pend_r <= div_pend_s;
            pend_r     <= pend_s;
            running_r  <= running_s;
            q_pos_r    <= q_pos_s;
            tick_r     <= tick_s;
            ack_r      <= ack_s;
        end
    end

    // Next-state logic: period sequencing and boundary-aligned divisor swap.
    always_comb begin
        running_s  = running_r;
        start_s    = 1'b0;
        apply_s    = 1'b0;
        div_cur_s  = div_cur_r;
        div_pend_s = div_pend_r;
        pend_s     = pend_r;
        ack_s      = 1'b0;
        cnt_s      = cnt_r;
        q_pos_s    = q_pos_r;
        tick_s     = 1'b0;

        if (!running_r) begin
            // Idle: clk_out is low, so a pending divisor is safe to take now.
            apply_s   = pend_r;
            running_s = en;
            start_s   = en;
        end else if (cnt_r == (div_cur_r - ONE)) begin
            // Period boundary: either start the next period or go idle.
            apply_s   = pend_r & en;
            running_s = en;
            start_s   = en;
        end else begin
            apply_s   = 1'b0;
            running_s = 1'b1;
            start_s   = 1'b0;
        end

        if (apply_s) begin
            div_cur_s = div_pend_r;
            ack_s     = 1'b1;
        end else begin
            div_cur_s = div_cur_r;
            ack_s     = 1'b0;
        end

        // A load on the same edge as an apply stays pending for the next boundary.
        if (div_load) begin
            div_pend_s = clamp_div(div_in);
            pend_s     = 1'b1;
        end else begin
            div_pend_s = div_pend_r;
            pend_s     = pend_r & ~apply_s;
        end

        if (!running_s) begin
            cnt_s   = ZERO;
            q_pos_s = 1'b0;
            tick_s  = 1'b0;
        end else if (start_s) begin
            // H >= 1 for every legal divisor, so the first cycle is always high.
            cnt_s   = ZERO;
            q_pos_s = 1'b1;
            tick_s  = 1'b1;
        end else begin
            cnt_s   = cnt_r + ONE;
            q_pos_s = ((cnt_r + ONE) < high_len(div_cur_r));
            tick_s  = 1'b0;
        end
    end

    generate
        if (NEG_MODE) begin : g_neg
            // Negedge stage: stretches the high phase by half a cycle for odd N.
            always_ff @(negedge clk_in or negedge reset_n) begin
                if (!reset_n) begin
                    q_neg_r <= 1'b0;
                end else begin
                    q_neg_r <= q_pos_r;
                end
            end
        end else begin : g_no_neg
            assign q_neg_r = 1'b0;
        end
    endgenerate

    // Output select. The mux select follows div_cur, which only changes while
    // q_neg is low, so both mux inputs agree whenever the select moves.
    always_comb begin
        if (NEG_MODE && div_cur_r[0]) begin
            clk_out = q_pos_r | q_neg_r;
        end else begin
            clk_out = q_pos_r;
        end
    end

    assign tick    = tick_r;
    assign div_ack = ack_r;
    assign busy    = pend_r;

endmodule
